// File: rtl/sched_host_ctrl.sv
// Host-side job controller: accepts a tagged job, pulses the scheduler, returns cycles/tag.
// Optional WAIT watchdog is compiled in when SCHED_TIMEOUT_EN is defined.
module sched_host_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TAG_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    output logic             sched_start,
    input  logic             sched_done,
    input  logic [31:0]      sched_cycle_count,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_cycles,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [15:0]      jobs_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   done_hit;
    logic   wd_expire;

    assign accept   = req_valid && req_ready;
    assign done_hit = (state == WAIT) && sched_done;

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == ARM)
            wait_cnt <= '0;
        else if (state == WAIT)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // A done in the same cycle as expiry takes priority (expiry requires !sched_done).
    assign wd_expire = (state == WAIT) && !sched_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign wd_expire      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                 state_nxt = ARM;
            ARM:     if (!sched_done)            state_nxt = WAIT;
            WAIT:    if (done_hit || wd_expire)  state_nxt = RESP;
            RESP:    if (rsp_ready)              state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !rst;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sched_start <= 1'b0;
            rsp_tag     <= '0;
            rsp_cycles  <= '0;
            rsp_timeout <= 1'b0;
            jobs_done   <= '0;
        end else begin
            sched_start <= (state == ARM) && !sched_done;
            if (accept)
                rsp_tag <= req_tag;
            if (done_hit) begin
                rsp_cycles  <= sched_cycle_count;
                rsp_timeout <= 1'b0;
            end else if (wd_expire) begin
                rsp_cycles  <= '1;
                rsp_timeout <= 1'b1;
            end
            if ((state == RESP) && rsp_ready)
                jobs_done <= jobs_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_sched_host_ctrl.sv
// Directed bench for sched_host_ctrl: vector table plus multi-cycle corner sequences.
// A second instance with TIMEOUT_CYCLES=16 covers the watchdog (SCHED_TIMEOUT_EN builds).
module tb_sched_host_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, sched_done, rsp_ready;
    logic [7:0]  req_tag;
    logic [31:0] sched_cycle_count;

    logic        req_ready, sched_start, rsp_valid, rsp_timeout, busy;
    logic [7:0]  rsp_tag;
    logic [31:0] rsp_cycles;
    logic [15:0] jobs_done;

    logic        t_req_ready, t_sched_start, t_rsp_valid, t_rsp_timeout, t_busy;
    logic [7:0]  t_rsp_tag;
    logic [31:0] t_rsp_cycles;
    logic [15:0] t_jobs_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sched_host_ctrl #(.TAG_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .sched_start(sched_start), .sched_done(sched_done),
        .sched_cycle_count(sched_cycle_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout),
        .busy(busy), .jobs_done(jobs_done)
    );

    sched_host_ctrl #(.TIMEOUT_CYCLES(16), .TAG_W(8)) dut_t (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(t_req_ready), .req_tag(req_tag),
        .sched_start(t_sched_start), .sched_done(sched_done),
        .sched_cycle_count(sched_cycle_count),
        .rsp_valid(t_rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(t_rsp_tag),
        .rsp_cycles(t_rsp_cycles), .rsp_timeout(t_rsp_timeout),
        .busy(t_busy), .jobs_done(t_jobs_done)
    );

    typedef struct {
        logic        rv;
        logic [7:0]  tag;
        logic        done;
        logic [31:0] cnt;
        logic        rr;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] pk(input logic rdy, input logic st, input logic vld,
                                       input logic bsy, input logic to, input logic [7:0] tg,
                                       input logic [31:0] cy, input logic [15:0] jb);
        return {3'b000, rdy, st, vld, bsy, to, tg, cy, jb};
    endfunction

    function automatic logic [63:0] pk_main();
        return pk(req_ready, sched_start, rsp_valid, busy, rsp_timeout, rsp_tag, rsp_cycles, jobs_done);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge; outputs are then sampled mid-cycle.
    task automatic step(input logic rv, input logic [7:0] tg, input logic d,
                        input logic [31:0] cn, input logic rr);
        @(negedge clk);
        req_valid = rv; req_tag = tg; sched_done = d; sched_cycle_count = cn; rsp_ready = rr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; req_tag = '0; sched_done = 1'b0;
        sched_cycle_count = '0; rsp_ready = 1'b0;
        #1;
        check("reset_state", pk_main(), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic addv(input logic rv, input logic [7:0] tg, input logic d,
                        input logic [31:0] cn, input logic rr, input logic [63:0] e);
        vecs.push_back('{rv, tg, d, cn, rr, e});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        int waits;
        int starts;
        logic got;

        // Job A: immediate done; job B: done held high at accept, back-pressured response.
        addv(1, 8'hA3, 0, 32'd0,   1, pk(1,0,0,0,0,8'h00,32'd0,16'd0));
        addv(0, 8'h00, 0, 32'd0,   1, pk(0,0,0,1,0,8'hA3,32'd0,16'd0));
        addv(0, 8'h00, 1, 32'd7,   1, pk(0,1,0,1,0,8'hA3,32'd0,16'd0));
        addv(0, 8'h00, 1, 32'd7,   1, pk(0,0,1,1,0,8'hA3,32'd7,16'd0));
        addv(0, 8'h00, 1, 32'd7,   0, pk(1,0,0,0,0,8'hA3,32'd7,16'd1));
        addv(1, 8'h3C, 1, 32'd7,   0, pk(1,0,0,0,0,8'hA3,32'd7,16'd1));
        addv(0, 8'h00, 1, 32'd7,   0, pk(0,0,0,1,0,8'h3C,32'd7,16'd1));
        addv(0, 8'h00, 1, 32'd7,   0, pk(0,0,0,1,0,8'h3C,32'd7,16'd1));
        addv(0, 8'h00, 0, 32'd7,   0, pk(0,0,0,1,0,8'h3C,32'd7,16'd1));
        addv(0, 8'h00, 0, 32'd100, 0, pk(0,1,0,1,0,8'h3C,32'd7,16'd1));
        addv(0, 8'h00, 0, 32'd100, 0, pk(0,0,0,1,0,8'h3C,32'd7,16'd1));
        addv(0, 8'h00, 1, 32'h12345678, 0, pk(0,0,0,1,0,8'h3C,32'd7,16'd1));
        addv(0, 8'h00, 1, 32'h12345678, 0, pk(0,0,1,1,0,8'h3C,32'h12345678,16'd1));
        addv(1, 8'h99, 1, 32'h12345678, 0, pk(0,0,1,1,0,8'h3C,32'h12345678,16'd1));
        addv(0, 8'h00, 1, 32'h12345678, 1, pk(0,0,1,1,0,8'h3C,32'h12345678,16'd1));
        addv(0, 8'h00, 1, 32'h12345678, 0, pk(1,0,0,0,0,8'h3C,32'h12345678,16'd2));
        addv(0, 8'h00, 1, 32'h12345678, 0, pk(1,0,0,0,0,8'h3C,32'h12345678,16'd2));

        rst = 1'b1; req_valid = 1'b0; req_tag = '0; sched_done = 1'b0;
        sched_cycle_count = '0; rsp_ready = 1'b0;
        do_reset();

        // Watchdog: sched_done held low on the 16-cycle instance.
        step(1, 8'h77, 0, 32'd0, 0);
        step(0, 8'h00, 0, 32'd0, 0);
        waits = 0; got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            step(0, 8'h00, 0, 32'd0, 0);
            if (t_rsp_valid) got = 1'b1; else waits++;
        end
`ifdef SCHED_TIMEOUT_EN
        check("wd_wait_cycles", 64'(waits), 64'd16);
        check("wd_result", {t_rsp_timeout, t_rsp_cycles, t_rsp_tag}, {1'b1, 32'hFFFF_FFFF, 8'h77});
`else
        check("wd_absent_wait", 64'(waits), 64'd40);
`endif
        check("wd_main_waiting", {busy, rsp_valid}, 2'b10);
        step(0, 8'h00, 1, 32'd99, 0);
        step(0, 8'h00, 1, 32'd99, 0);
        check("wd_main_result", {rsp_valid, rsp_timeout, rsp_cycles}, {1'b1, 1'b0, 32'd99});
`ifdef SCHED_TIMEOUT_EN
        check("wd_result_stable", {t_rsp_valid, t_rsp_timeout, t_rsp_cycles}, {1'b1, 1'b1, 32'hFFFF_FFFF});
`else
        check("wd_absent_result", {t_rsp_valid, t_rsp_timeout, t_rsp_cycles}, {1'b1, 1'b0, 32'd99});
`endif
        step(0, 8'h00, 1, 32'd99, 1);
        step(0, 8'h00, 1, 32'd99, 0);
        check("wd_back_idle", {t_busy, t_req_ready, busy, req_ready}, 4'b0101);

        // Done arriving in the very cycle the watchdog would expire: done wins.
        step(1, 8'h88, 0, 32'd0, 0);
        step(0, 8'h00, 0, 32'd0, 0);
        for (int k = 1; k <= 16; k++) step(0, 8'h00, (k == 16), (k == 16) ? 32'd123 : 32'd0, 0);
        step(0, 8'h00, 1, 32'd123, 0);
        check("coincide_done_wins", {t_rsp_valid, t_rsp_timeout, t_rsp_cycles, t_rsp_tag},
              {1'b1, 1'b0, 32'd123, 8'h88});

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rv, vecs[i].tag, vecs[i].done, vecs[i].cnt, vecs[i].rr);
            check($sformatf("vec%0d", i), pk_main(), vecs[i].exp);
        end

        // Tag 5A, scheduler reports done after 41 WAIT cycles with count 41.
        do_reset();
        starts = 0;
        step(1, 8'h5A, 0, 32'd0, 1);
        step(0, 8'h00, 0, 32'd0, 1);
        for (int k = 1; k <= 41; k++) begin
            step(0, 8'h00, (k == 41), 32'(k), 1);
            if (sched_start) starts++;
        end
        step(0, 8'h00, 1, 32'd41, 1);
        if (sched_start) starts++;
        check("j41_rsp", {rsp_valid, rsp_timeout, rsp_tag, rsp_cycles}, {1'b1, 1'b0, 8'h5A, 32'd41});
        step(0, 8'h00, 1, 32'd41, 0);
        if (sched_start) starts++;
        check("j41_jobs", {rsp_valid, jobs_done}, {1'b0, 16'd1});
        check("j41_starts", 64'(starts), 64'd1);

        // Done high at accept holds ARM; done drops at cycle 10, start at cycle 11.
        starts = 0;
        step(1, 8'h11, 1, 32'd0, 0);
        for (int c = 1; c <= 10; c++) begin
            step(0, 8'h00, (c < 10), 32'd0, 0);
            if (sched_start) starts++;
        end
        check("arm_hold", {starts[7:0], busy, req_ready}, {8'd0, 1'b1, 1'b0});
        step(0, 8'h00, 0, 32'd0, 0);
        check("arm_start_c11", sched_start, 1'b1);
        step(0, 8'h00, 1, 32'd55, 0);
        check("arm_start_once", sched_start, 1'b0);

        // Response held for 20 cycles, handshake on cycle 21.
        for (int c = 1; c <= 20; c++) begin
            step(1, 8'hEE, (c % 2) == 1, 32'(c * 3), 0);
            check($sformatf("hold%0d", c), {rsp_valid, req_ready, rsp_timeout, rsp_tag, rsp_cycles},
                  {1'b1, 1'b0, 1'b0, 8'h11, 32'd55});
        end
        step(0, 8'h00, 0, 32'd0, 1);
        check("hold_c21", {rsp_valid, jobs_done}, {1'b1, 16'd1});
        step(0, 8'h00, 0, 32'd0, 0);
        check("hold_idle", {rsp_valid, busy, req_ready, jobs_done}, {1'b0, 1'b0, 1'b1, 16'd2});

        // Reset pulsed mid-WAIT aborts the job silently.
        step(1, 8'h21, 0, 32'd0, 1);
        step(0, 8'h00, 0, 32'd0, 1);
        step(0, 8'h00, 0, 32'd0, 1);
        check("abort_in_wait", {busy, sched_start}, 2'b11);
        step(0, 8'h00, 0, 32'd0, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            check($sformatf("abort_rst%0d", c), pk_main(), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_release", pk_main(), pk(1,0,0,0,0,8'h00,32'd0,16'd0));
        step(0, 8'h00, 0, 32'd0, 1);
        check("abort_no_rsp", pk_main(), pk(1,0,0,0,0,8'h00,32'd0,16'd0));
        step(1, 8'h42, 0, 32'd0, 1);
        step(0, 8'h00, 0, 32'd0, 1);
        step(0, 8'h00, 1, 32'd3, 1);
        step(0, 8'h00, 1, 32'd3, 1);
        check("abort_next_rsp", {rsp_valid, rsp_tag, rsp_cycles}, {1'b1, 8'h42, 32'd3});
        step(0, 8'h00, 1, 32'd3, 0);
        check("abort_next_jobs", jobs_done, 16'd1);

        // jobs_done wraps from FFFF to 0.
        @(negedge clk);
        force dut.jobs_done = 16'hFFFF;
        @(negedge clk);
        release dut.jobs_done;
        #1;
        check("wrap_preload", jobs_done, 16'hFFFF);
        step(1, 8'h05, 0, 32'd0, 1);
        step(0, 8'h00, 0, 32'd0, 1);
        step(0, 8'h00, 1, 32'd9, 1);
        step(0, 8'h00, 1, 32'd9, 1);
        check("wrap_resp", jobs_done, 16'hFFFF);
        step(0, 8'h00, 1, 32'd9, 0);
        check("wrap_zero", jobs_done, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sched_host_ctrl.md
SCHED_HOST_CTRL -- requirements
Module: sched_host_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the watchdog limit in clk cycles spent in WAIT; legal range 2..2^20.
REQ-002 Parameter TAG_W, default 8, is the job tag width.
REQ-003 Port clk  input  1  is the single clock; all logic is rising-edge.
REQ-004 Port rst  input  1  is an asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  signals that the host offers a job.
REQ-006 Port req_ready  output  1  signals that the controller accepts a job.
REQ-007 Port req_tag  input  TAG_W  is the host job identifier.
REQ-008 Port sched_start  output  1  is the start pulse to the scheduler.
REQ-009 Port sched_done  input  1  is the scheduler done level, held high once finished.
REQ-010 Port sched_cycle_count  input  32  is the scheduler cycle counter.
REQ-011 Port rsp_valid  output  1  signals that a result is available.
REQ-012 Port rsp_ready  input  1  signals that the host accepts the result.
REQ-013 Port rsp_tag  output  TAG_W  echoes the accepted req_tag.
REQ-014 Port rsp_cycles  output  32  is the captured sched_cycle_count, or 32'hFFFF_FFFF on timeout.
REQ-015 Port rsp_timeout  output  1  is high when the result is a watchdog expiry.
REQ-016 Port busy  output  1  is high in every state except IDLE.
REQ-017 Port jobs_done  output  16  counts completed response handshakes.

Function
REQ-018 The FSM shall have states IDLE, ARM, WAIT and RESP, fully encoded; any illegal encoding shall return to IDLE on the next clk.
REQ-019 IDLE: req_ready=1; on req_valid&req_ready the block shall latch req_tag and go to ARM next cycle; req_ready=0 in all other states.
REQ-020 ARM: the block shall stay while sched_done=1; when sched_done=0 it shall register sched_start=1 for exactly one cycle and go to WAIT, clearing the wait counter.
REQ-021 sched_start shall be a registered output, high for exactly one clk per accepted job, and never high outside the ARM->WAIT transition.
REQ-022 WAIT: the wait counter shall increment every cycle; on sched_done=1 the block shall capture sched_cycle_count into rsp_cycles in that same cycle, set rsp_timeout=0 and go to RESP.
REQ-023 WAIT timeout: when the wait counter equals TIMEOUT_CYCLES-1 and sched_done=0, the block shall set rsp_cycles=32'hFFFF_FFFF and rsp_timeout=1, then go to RESP.
REQ-024 If done and timeout coincide in the same cycle, done shall win (normal capture, rsp_timeout=0).
REQ-025 RESP: rsp_valid=1; rsp_tag, rsp_cycles and rsp_timeout shall stay stable until rsp_valid&rsp_ready, after which the block shall go to IDLE next cycle.
REQ-026 jobs_done shall increment by 1 on each RESP handshake and wrap 16'hFFFF->0.
REQ-027 Minimum job turnaround shall be IDLE->ARM->WAIT->RESP->IDLE = 4 cycles with immediate done and rsp_ready=1.
REQ-028 req_valid deasserting while not ready shall have no effect; there is no request buffering.

Reset
REQ-029 While rst=1, the state shall be IDLE and sched_start, rsp_valid, rsp_timeout, rsp_cycles, rsp_tag, jobs_done and the wait counter shall be 0; busy=0 and req_ready=0.
REQ-030 Assertion of rst mid-job (any state) shall abort the job immediately with no response; req_ready=1 on the first clk after rst deasserts.

Configuration
REQ-031 Macro SCHED_TIMEOUT_EN defined: the wait counter and watchdog per REQ-023/024 shall be present.
REQ-032 Macro SCHED_TIMEOUT_EN undefined: no wait counter; WAIT shall exit only on sched_done; rsp_timeout tied 0; TIMEOUT_CYCLES unused.

Verification
REQ-033 tag 8'h5A, scheduler done after 41 cycles with count 41, rsp_ready=1 -> one sched_start pulse, rsp_tag=5A, rsp_cycles=41, rsp_timeout=0, jobs_done=1.
REQ-034 SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, sched_done held 0 -> RESP after 16 WAIT cycles, rsp_cycles=FFFF_FFFF, rsp_timeout=1.
REQ-035 sched_done=1 on request accept -> block holds in ARM, no sched_start; done drops at cycle 10 -> start pulse at cycle 11.
REQ-036 rsp_ready low for 20 cycles in RESP -> outputs stable, req_ready=0, handshake on cycle 21, then IDLE.
REQ-037 rst pulsed 3 cycles in WAIT -> all outputs 0, no response, next job completes normally with jobs_done unchanged from 0.
REQ-038 preload jobs_done=16'hFFFF via 65535 jobs (or force) -> next handshake gives jobs_done=0.
